// File: rtl/lsu_mem_master_pkg.sv
// Shared types and constants for the load/store unit: access sizes, memory
// write-enable encoding and controller states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b01;
    localparam logic [1:0] WE_BYTE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_STORE_HI,
        ST_RESP
    } state_e;

    function automatic logic [2:0] size_nbytes(input size_e sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_master_load_extend.sv
// Sign/zero extension of raw memory read data to the requested load size.
module load_extend
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] mem_rd,
    input  size_e                 size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] ext_data
);

    always_comb begin
        ext_data = mem_rd;
        case (size)
            SZ_B:    ext_data = {{(DATA_WIDTH-8){~is_unsigned & mem_rd[7]}}, mem_rd[7:0]};
            SZ_H:    ext_data = {{(DATA_WIDTH-16){~is_unsigned & mem_rd[15]}}, mem_rd[15:0]};
            default: ext_data = mem_rd;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit: one request at a time from the core, drives a byte-addressed
// memory with word/byte writes only (halfword stores become two byte writes).
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_BYTES  = 2**17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam logic [DATA_WIDTH:0] MEM_LIMIT = (DATA_WIDTH+1)'(MEM_BYTES);

    state_e                state_q, state_d;
    logic                  wr_q, wr_d;
    size_e                 size_q, size_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [DATA_WIDTH:0]   end_addr;
    logic                  acc_err;
    logic [DATA_WIDTH-1:0] ext_data;

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .mem_rd      (mem_rd),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ext_data    (ext_data)
    );

    // One extra bit so addresses near the top of the address space cannot wrap past the limit.
    assign end_addr = {1'b0, addr_q} + (DATA_WIDTH+1)'(size_nbytes(size_q));
    assign acc_err  = (size_q == SZ_ILL) || (end_addr > MEM_LIMIT);

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        mem_we   = WE_NONE;
        mem_addr = addr_q;
        mem_wd   = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    wr_d    = req_wr;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                err_d   = acc_err;
                rdata_d = '0;
                state_d = ST_RESP;
                if (!acc_err) begin
                    if (!wr_q) begin
                        rdata_d = ext_data;
                    end else begin
                        case (size_q)
                            SZ_W: begin
                                mem_we = WE_WORD;
                                mem_wd = wdata_q;
                            end
                            SZ_H: begin
                                mem_we  = WE_BYTE;
                                mem_wd  = {{(DATA_WIDTH-8){1'b0}}, wdata_q[7:0]};
                                state_d = ST_STORE_HI;
                            end
                            default: begin
                                mem_we = WE_BYTE;
                                mem_wd = {{(DATA_WIDTH-8){1'b0}}, wdata_q[7:0]};
                            end
                        endcase
                    end
                end
            end
            ST_STORE_HI: begin
                mem_we   = WE_BYTE;
                mem_addr = addr_q + DATA_WIDTH'(1);
                mem_wd   = {{(DATA_WIDTH-8){1'b0}}, wdata_q[15:8]};
                state_d  = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered ready keeps it low during reset and releases it one cycle later.
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: a byte-array memory model, directed and
// random requests, expected writes/responses queued and checked by a monitor.
module tb_lsu_mem_master;

    localparam int unsigned MEM_BYTES = 2**17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    lsu_mem_master #(.DATA_WIDTH(32), .MEM_BYTES(MEM_BYTES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    // Environment memory (driven by the DUT) and reference memory (driven by the model).
    logic [7:0] emem   [0:MEM_BYTES-1];
    logic [7:0] refmem [0:MEM_BYTES-1];

    always_comb begin
        mem_rd = '0;
        for (int k = 0; k < 4; k++)
            if (longint'(mem_addr) + k < MEM_BYTES)
                mem_rd[8*k +: 8] = emem[mem_addr + k];
    end

    always @(posedge clk) begin
        if (mem_we == 2'b01) begin
            for (int k = 0; k < 4; k++)
                if (longint'(mem_addr) + k < MEM_BYTES)
                    emem[mem_addr + k] <= mem_wd[8*k +: 8];
        end else if (mem_we == 2'b11) begin
            if (longint'(mem_addr) < MEM_BYTES)
                emem[mem_addr] <= mem_wd[7:0];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          cyc;
    } wr_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    wr_t  wq[$];
    rsp_t rq[$];

    always @(negedge clk) begin
        wr_t  ew;
        rsp_t er;
        if (rst_n) begin
            if (mem_we !== 2'b00) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: we=%b addr=%h wd=%h cycle %0d expected none",
                             mem_we, mem_addr, mem_wd, cyc);
                end else begin
                    ew = wq.pop_front();
                    chk("wr_addr_wd", {mem_addr, mem_wd}, {ew.addr, ew.wd});
                    chk("wr_we_cycle", {30'd0, mem_we, cyc}, {30'd0, ew.we, ew.cyc});
                end
            end
            if (rsp_valid === 1'b1) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: err=%b rdata=%h cycle %0d expected none",
                             rsp_err, rsp_rdata, cyc);
                end else begin
                    er = rq.pop_front();
                    chk("rsp_err_rdata", {31'd0, rsp_err, rsp_rdata}, {31'd0, er.err, er.rdata});
                    chk("rsp_cycle", 64'(cyc), 64'(er.cyc));
                end
            end
        end
    end

    int last_n   = 0;
    int last_lat = 3;
    bit chain    = 1'b0;

    // Issues a request at a negedge; returns at the negedge of the ACCESS cycle.
    // b2b: the caller issues the next request immediately, keeping req_valid high.
    task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit b2b);
        int     w;
        int     n;
        int     nb;
        bit     err;
        longint v;
        rsp_t   r;
        wr_t    e;
        req_valid    = 1'b1;
        req_wr       = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (req_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles expected 1", req_ready, w);
            req_valid = 1'b0;
            chain = 1'b0;
            return;
        end
        n = cyc + 1;
        if (chain) chk("b2b_accept_cycle", 64'(n), 64'(last_n + last_lat));

        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        err = (sz == 2'd3) || (longint'(addr) + nb > MEM_BYTES);
        r.err   = err;
        r.rdata = '0;
        r.cyc   = n + ((!err && wr && sz == 2'd1) ? 2 : 1);
        if (!err && !wr) begin
            v = 0;
            for (int i = 0; i < nb; i++) v += longint'(refmem[addr + i]) << (8 * i);
            if (!uns && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
            r.rdata = v[31:0];
        end else if (!err && wr) begin
            for (int i = 0; i < nb; i++) refmem[addr + i] = wdata[8*i +: 8];
            if (nb == 4) begin
                e.we = 2'b01; e.addr = addr; e.wd = wdata; e.cyc = n;
                wq.push_back(e);
            end else begin
                for (int i = 0; i < nb; i++) begin
                    e.we = 2'b11; e.addr = addr + i; e.wd = {24'd0, wdata[8*i +: 8]}; e.cyc = n + i;
                    wq.push_back(e);
                end
            end
        end
        rq.push_back(r);
        last_n   = n;
        last_lat = (r.cyc - n) + 2;
        chain    = b2b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        chain = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  b;
        logic [7:0]  old_hi;
        bit          rwr, rb2b, runs;
        logic [1:0]  rsz;
        logic [31:0] raddr;
        int          sel;

        for (int i = 0; i < MEM_BYTES; i++) begin
            b = 8'($urandom);
            emem[i]   = b;
            refmem[i] = b;
        end
        emem[32'h10000] = 8'h78; refmem[32'h10000] = 8'h78;
        emem[32'h10001] = 8'h56; refmem[32'h10001] = 8'h56;
        emem[32'h10002] = 8'h34; refmem[32'h10002] = 8'h34;
        emem[32'h10003] = 8'h12; refmem[32'h10003] = 8'h12;
        emem[32'h10005] = 8'h80; refmem[32'h10005] = 8'h80;

        #3;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_wd", 64'(mem_wd), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("ready_at_release", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_release", 64'(req_ready), 64'd1);

        issue(1'b0, 2'd2, 1'b0, 32'h10000, 32'h0, 1'b0);          idle(3);
        issue(1'b0, 2'd0, 1'b0, 32'h10005, 32'h0, 1'b1);
        issue(1'b0, 2'd0, 1'b1, 32'h10005, 32'h0, 1'b0);          idle(3);
        issue(1'b1, 2'd1, 1'b0, 32'h10002, 32'hCAFEBEEF, 1'b1);
        issue(1'b0, 2'd1, 1'b1, 32'h10002, 32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b0, 32'h10002, 32'h0, 1'b0);          idle(3);
        issue(1'b1, 2'd2, 1'b0, 32'h1FFFE, 32'h11223344, 1'b0);   idle(3);
        issue(1'b1, 2'd3, 1'b0, 32'h10008, 32'h55667788, 1'b1);
        issue(1'b0, 2'd3, 1'b0, 32'h10008, 32'h0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h1FFFC, 32'hA1B2C3D4, 1'b1);
        issue(1'b0, 2'd0, 1'b0, 32'h1FFFF, 32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b0, 32'h1FFFF, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b1, 32'hFFFFFFFE, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h1FFFC, 32'h0, 1'b0);          idle(3);

        for (int t = 0; t < 300; t++) begin
            rwr  = 1'($urandom_range(0, 1));
            runs = 1'($urandom_range(0, 1));
            rb2b = 1'($urandom_range(0, 1));
            rsz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sel  = $urandom_range(0, 9);
            if (sel < 7)       raddr = 32'h10000 + $urandom_range(0, 63);
            else if (sel == 7) raddr = MEM_BYTES - 8 + $urandom_range(0, 15);
            else if (sel == 8) raddr = $urandom;
            else               raddr = $urandom_range(0, MEM_BYTES - 1);
            issue(rwr, rsz, runs, raddr, $urandom, rb2b);
            if (!rb2b) idle($urandom_range(0, 3));
        end
        idle(4);

        old_hi = refmem[32'h10011];
        issue(1'b1, 2'd1, 1'b0, 32'h10010, 32'h0000A55A, 1'b0);
        void'(rq.pop_back());
        void'(wq.pop_back());
        refmem[32'h10011] = old_hi;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_mem_we", 64'(mem_we), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        chain = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after_release", 64'(req_ready), 64'd1);
        chk("midrst_low_byte", 64'(emem[32'h10010]), 64'h5A);
        chk("midrst_high_byte", 64'(emem[32'h10011]), 64'(old_hi));
        issue(1'b0, 2'd1, 1'b1, 32'h10010, 32'h0, 1'b0);
        idle(6);

        chk("rsp_queue_empty", 64'(rq.size()), 64'd0);
        chk("wr_queue_empty", 64'(wq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store unit sitting between the pipelined core's memory stage and the byte-addressed data memory. Accepts one load or store request at a time from the core and drives the memory's `WE`/`A`/`WD` port using the memory's write-enable encoding. Sign- or zero-extends load data and returns a one-cycle response. The memory has no halfword write, so halfword stores are split into two byte writes.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data and address width.
- `MEM_BYTES`, 2**17: highest legal byte address + 1; accesses past it are errors.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  async active-low reset.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  zero-extend load (lbu/lhu).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, LSB-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_err`  out  1  qualifies `rsp_valid`: illegal size or out of range.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `mem_we`  out  2  00 read/none, 01 word write, 11 byte write; 10 is never driven.
- `mem_addr`  out  32  memory byte address.
- `mem_wd`  out  32  memory write data.
- `mem_rd`  in  32  combinational read data: bytes at A+3..A.

## Operation
- FSM states: IDLE, ACCESS, STORE_HI, RESP.
- IDLE:
  - `req_ready`=1.
  - On handshake, latch wr, size, unsigned, addr and wdata; go to ACCESS.
- ACCESS:
  - Error check: err if size==11, or if addr + nbytes > `MEM_BYTES` (nbytes = 1/2/4).
  - If err: `mem_we`=00; go to RESP.
  - Load: `mem_we`=00, `mem_addr`=addr. Capture `mem_rd` at the clock edge:
    - byte: bits [7:0].
    - half: bits [15:0].
    - word: all 32 bits.
    - Extend by `req_unsigned`; go to RESP.
  - sw: `mem_we`=01, `mem_wd`=wdata; go to RESP.
  - sb: `mem_we`=11, `mem_wd`={24'b0, wdata[7:0]}; go to RESP.
  - sh: `mem_we`=11, `mem_wd`={24'b0, wdata[7:0]}; go to STORE_HI.
- STORE_HI: `mem_we`=11, `mem_addr`=addr+1, `mem_wd`={24'b0, wdata[15:8]}; go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_err` and `rsp_rdata` held valid; go to IDLE.
  - `req_ready`=0; a request held through RESP is accepted in the next IDLE cycle.
- Outside ACCESS/STORE_HI: `mem_we`=00, `mem_addr`=latched addr, `mem_wd`=0.
- Misaligned addresses are legal; the memory handles unaligned word access.

## Timing
- Reset values (asserted immediately, asynchronously):
  - State IDLE.
  - `req_ready`, `rsp_valid`, `rsp_err`, `rsp_rdata`, `mem_we`, `mem_wd`, `mem_addr` all 0.
  - `req_ready` = 0 while `rst_n` is low; it rises the first cycle after release.
- Latency from acceptance at edge N:
  - Load, sb, sw, or error: `rsp_valid` high in cycle N+2.
  - sh: `rsp_valid` high in cycle N+3.
- Throughput: one request per 3 cycles (sh: 4).
- Memory writes commit on the `clk` edge that ends ACCESS/STORE_HI.
- Reset mid-sh after the low byte is written: the low byte stays written. The high byte is never written and no response is issued.
- `mem_we`, `mem_addr` and `mem_wd` are decoded from registered state only; no combinational path from `req_*`.

## Structure
- `lsu_pkg`:
  - size enum (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_ILL`).
  - memory WE constants (`WE_NONE`=00, `WE_WORD`=01, `WE_BYTE`=11).
  - state enum.
- Sub-module `load_extend`: combinational; inputs `mem_rd`, size, unsigned; output 32-bit extended value.

## Test plan
- lw at 0x10000, memory bytes 78 56 34 12 → `rsp_rdata`=0x12345678 at N+2, `rsp_err`=0.
- Byte 0x80 at 0x10005:
  - lb → 0xFFFFFF80.
  - lbu → 0x00000080.
  - `mem_we`=00 throughout.
- sh wdata 0xCAFEBEEF at 0x10002:
  - N+1: `mem_we`=11, addr 0x10002, wd 0xEF.
  - N+2: `mem_we`=11, addr 0x10003, wd 0xBE.
  - `rsp_valid` at N+3.
  - Follow-up lhu at 0x10002 → 0x0000BEEF; lh → 0xFFFFBEEF.
- Errors:
  - sw at 0x1FFFE (MEM_BYTES=2**17) → `rsp_err`=1, `rsp_rdata`=0, `mem_we` never nonzero.
  - size 11 → same behaviour.
- `req_valid` held high across back-to-back requests → `req_ready` low in ACCESS/STORE_HI/RESP; the second request is accepted exactly in the IDLE cycle after RESP.
- `rst_n` low in STORE_HI of an sh → `mem_we`=00 in the same cycle, only the low byte written, no `rsp_valid`; `req_ready`=1 one cycle after release.
